zquench_sequencer: RTL
======================

// Module: zquench_sequencer
// PURPOSE
//  Active-quench timing controller for the SPAD front end. Synchronises the
//  avalanche comparator pulse, drives quench / recharge-reset with
//  programmable widths and dead time, and counts detected and blocked events.
//  Sits between the comparator input pin and the quench/reset drivers.
//  Replaces the fixed single-cycle quench/reset sequence with a configurable one.
// PARAMETERS
//  CNT_W      16  width of timing-length config and down-counter
//  EVT_W      32  width of event counters
//  DEF_QUENCH  5  quench length after reset, cycles
//  DEF_DEAD   10  dead-time length after reset, cycles
//  DEF_RESET   5  recharge-reset length after reset, cycles
// PORTS
//  clk            in   1      system clock (50 MHz)
//  rst            in   1      synchronous reset, active high
//  en             in   1      enable Geiger-mode operation
//  pulse          in   1      async avalanche comparator output
//  cfg_quench_len in   CNT_W  quench width, cycles
//  cfg_dead_len   in   CNT_W  dead time between quench and reset, cycles
//  cfg_reset_len  in   CNT_W  recharge-reset width, cycles
//  cfg_load       in   1      strobe: capture cfg_* into shadow regs
//  cnt_clr        in   1      strobe: clear both event counters
//  geiger_mode_en out  1      bias-enable, registered copy of en
//  quench         out  1      quench driver, registered
//  spad_reset     out  1      recharge driver, registered
//  busy           out  1      1 in QUENCH/DEAD/RESET
//  event_cnt      out  EVT_W  accepted avalanches, saturating
//  blocked_cnt    out  EVT_W  rising edges lost while busy, saturating
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0; active cfg = DEF_*.
//  Sync: pulse -> f1 -> f2 flops; f1/f2 forced 0 while en=0.
//    rise = f1 & ~f2 (combinational).
//  States: IDLE=0, ARMED=1, QUENCH=2, DEAD=3, RESET=4. Others -> IDLE.
//  Outputs are Moore, registered with the state:
//    quench=1 only in QUENCH; spad_reset=1 only in RESET.
//  IDLE:   en=1 -> ARMED.
//  ARMED:  rise -> QUENCH, load down-counter with max(q_len,1)-1,
//          event_cnt += 1.
//  QUENCH: counter==0 -> DEAD (dead_len>0) else RESET; else decrement.
//    Quench high exactly max(q_len,1) cycles.
//  DEAD:   low for exactly dead_len cycles (0 skips the state).
//  RESET:  high exactly max(reset_len,1) cycles, then ARMED.
//  Latency: first clk edge sampling pulse=1 is edge k; quench rises after
//    edge k+1. Pulse held high through ARMED does not retrigger; a new
//    low->high transition is required.
//  Blocked: rise while busy=1 -> blocked_cnt += 1. No sequence starts.
//  Counters saturate at all-ones. cnt_clr has priority over increment
//    in the same cycle: result is 0 and the event is dropped.
//  Config:
//    - cfg_load captures cfg_* into shadow in any state.
//    - Shadow copies to active only in IDLE/ARMED, on the cycle after load
//      or on re-entry to ARMED.
//    - A sequence in flight always finishes with the values it started with.
//  en=0 in any state -> IDLE next cycle; quench, spad_reset, busy = 0 next
//    cycle. An in-flight sequence is aborted. geiger_mode_en follows en
//    with 1-cycle delay.
//  rst mid-sequence: same as power-up reset. Shadow regs also return to DEF_*.
// TESTING
//  1. Defaults: en=1, single 3-cycle pulse
//     -> quench high 5 cyc, low 10, spad_reset high 5; event_cnt=1.
//  2. Latency: pulse rises just before edge k -> quench=1 after edge k+1.
//  3. Blocked: 2nd pulse 3 cyc after quench rise
//     -> blocked_cnt=1, event_cnt=1, no second quench.
//  4. Zero cfg: load q=0, d=0, r=0
//     -> quench 1 cyc, spad_reset the next cycle for 1 cyc, back to ARMED.
//  5. Abort + cfg: en=0 mid-DEAD -> all outputs 0 next cycle. cfg_load q=8
//     mid-QUENCH -> current quench stays 5 cyc, next one 8 cyc.
//  6. Saturation / clr: preload event_cnt to all-ones, pulse -> stays all-ones.
//     cnt_clr coincident with accepted rise -> event_cnt=0.

Source files
------------

// File: rtl/zquench_if.sv
// Signal bundle between the SPAD quench sequencer and its surroundings:
// comparator input, timing configuration, driver outputs and event counters.
interface zquench_if #(
    parameter int CNT_W = 16,
    parameter int EVT_W = 32
);
    logic             en;
    logic             pulse;
    logic [CNT_W-1:0] cfg_quench_len;
    logic [CNT_W-1:0] cfg_dead_len;
    logic [CNT_W-1:0] cfg_reset_len;
    logic             cfg_load;
    logic             cnt_clr;
    logic             geiger_mode_en;
    logic             quench;
    logic             spad_reset;
    logic             busy;
    logic [EVT_W-1:0] event_cnt;
    logic [EVT_W-1:0] blocked_cnt;

    modport slave (
        input  en, pulse, cfg_quench_len, cfg_dead_len, cfg_reset_len, cfg_load, cnt_clr,
        output geiger_mode_en, quench, spad_reset, busy, event_cnt, blocked_cnt
    );

    modport master (
        output en, pulse, cfg_quench_len, cfg_dead_len, cfg_reset_len, cfg_load, cnt_clr,
        input  geiger_mode_en, quench, spad_reset, busy, event_cnt, blocked_cnt
    );
endinterface

// File: rtl/zquench_sequencer.sv
// Active-quench timing controller: synchronises the avalanche pulse, then runs a
// programmable quench / dead-time / recharge-reset sequence and counts events.
module zquench_sequencer #(
    parameter int CNT_W      = 16,
    parameter int EVT_W      = 32,
    parameter int DEF_QUENCH = 5,
    parameter int DEF_DEAD   = 10,
    parameter int DEF_RESET  = 5
) (
    input  logic    clk,
    input  logic    rst,
    zquench_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_QUENCH = 3'd2,
        S_DEAD   = 3'd3,
        S_RESET  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEF_Q = CNT_W'(DEF_QUENCH);
    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DEAD);
    localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEF_RESET);

    // Down-counter preload so that a length of zero still yields one cycle.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    function automatic logic [EVT_W-1:0] sat_step(input logic [EVT_W-1:0] v,
                                                  input logic inc, input logic clr);
        if (clr)
            return '0;
        if (inc && (v != '1))
            return v + EVT_W'(1);
        return v;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             f1_q, f1_d, f2_q, f2_d;
    logic             geiger_q, geiger_d;
    logic             quench_q, quench_d;
    logic             spad_reset_q, spad_reset_d;
    logic             busy_q, busy_d;
    logic [EVT_W-1:0] event_cnt_q, event_cnt_d;
    logic [EVT_W-1:0] blocked_cnt_q, blocked_cnt_d;
    logic [CNT_W-1:0] shadow_quench_q, shadow_quench_d;
    logic [CNT_W-1:0] shadow_dead_q, shadow_dead_d;
    logic [CNT_W-1:0] shadow_reset_q, shadow_reset_d;
    logic [CNT_W-1:0] act_quench_q, act_quench_d;
    logic [CNT_W-1:0] act_dead_q, act_dead_d;
    logic [CNT_W-1:0] act_reset_q, act_reset_d;
    logic             rise;
    logic             accept;

    always_comb begin
        f1_d     = bus.en & bus.pulse;
        f2_d     = bus.en & f1_q;
        rise     = f1_q & ~f2_q;
        geiger_d = bus.en;
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;

        if (!bus.en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARMED;
                S_ARMED: begin
                    if (rise) begin
                        state_d = S_QUENCH;
                        cnt_d   = len_m1(act_quench_q);
                        accept  = 1'b1;
                    end
                end
                S_QUENCH: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (act_dead_q != '0) begin
                        state_d = S_DEAD;
                        cnt_d   = act_dead_q - CNT_W'(1);
                    end else begin
                        state_d = S_RESET;
                        cnt_d   = len_m1(act_reset_q);
                    end
                end
                S_DEAD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = S_RESET;
                        cnt_d   = len_m1(act_reset_q);
                    end
                end
                S_RESET: begin
                    if (cnt_q != '0)
                        cnt_d = cnt_q - CNT_W'(1);
                    else
                        state_d = S_ARMED;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register alongside it.
        quench_d     = (state_d == S_QUENCH);
        spad_reset_d = (state_d == S_RESET);
        busy_d       = (state_d == S_QUENCH) || (state_d == S_DEAD) || (state_d == S_RESET);

        event_cnt_d   = sat_step(event_cnt_q, accept, bus.cnt_clr);
        blocked_cnt_d = sat_step(blocked_cnt_q, rise & busy_q, bus.cnt_clr);

        shadow_quench_d = shadow_quench_q;
        shadow_dead_d   = shadow_dead_q;
        shadow_reset_d  = shadow_reset_q;
        if (bus.cfg_load) begin
            shadow_quench_d = bus.cfg_quench_len;
            shadow_dead_d   = bus.cfg_dead_len;
            shadow_reset_d  = bus.cfg_reset_len;
        end

        // Active timing is frozen while a sequence runs; it only follows the
        // shadow copy while the next state is idle or armed.
        act_quench_d = act_quench_q;
        act_dead_d   = act_dead_q;
        act_reset_d  = act_reset_q;
        if ((state_d == S_IDLE) || (state_d == S_ARMED)) begin
            act_quench_d = shadow_quench_q;
            act_dead_d   = shadow_dead_q;
            act_reset_d  = shadow_reset_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            f1_q            <= 1'b0;
            f2_q            <= 1'b0;
            geiger_q        <= 1'b0;
            quench_q        <= 1'b0;
            spad_reset_q    <= 1'b0;
            busy_q          <= 1'b0;
            event_cnt_q     <= '0;
            blocked_cnt_q   <= '0;
            shadow_quench_q <= DEF_Q;
            shadow_dead_q   <= DEF_D;
            shadow_reset_q  <= DEF_R;
            act_quench_q    <= DEF_Q;
            act_dead_q      <= DEF_D;
            act_reset_q     <= DEF_R;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            f1_q            <= f1_d;
            f2_q            <= f2_d;
            geiger_q        <= geiger_d;
            quench_q        <= quench_d;
            spad_reset_q    <= spad_reset_d;
            busy_q          <= busy_d;
            event_cnt_q     <= event_cnt_d;
            blocked_cnt_q   <= blocked_cnt_d;
            shadow_quench_q <= shadow_quench_d;
            shadow_dead_q   <= shadow_dead_d;
            shadow_reset_q  <= shadow_reset_d;
            act_quench_q    <= act_quench_d;
            act_dead_q      <= act_dead_d;
            act_reset_q     <= act_reset_d;
        end
    end

    assign bus.geiger_mode_en = geiger_q;
    assign bus.quench         = quench_q;
    assign bus.spad_reset     = spad_reset_q;
    assign bus.busy           = busy_q;
    assign bus.event_cnt      = event_cnt_q;
    assign bus.blocked_cnt    = blocked_cnt_q;
endmodule
